// File: rtl/lms_pkg.sv
// Shared widths, tap count, leakage shift and FSM encoding for the LMS weight-update block.
package lms_pkg;

  localparam int unsigned NTAP       = 16;
  localparam int unsigned SAMPLE_W   = 14;
  localparam int unsigned ERR_W      = 11;
  localparam int unsigned WEIGHT_W   = 32;
  localparam int unsigned LEAK_SHIFT = 12;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StDone
  } lms_state_e;

endpackage

// File: rtl/lms_tap_mac.sv
// Combinational single-tap update: multiply, shift by mu, optional leak, add, saturate to 32 bits.
// Leakage term is included only when LMS_LEAKAGE_EN is defined.
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int unsigned MU_SHIFT = 10
) (
  input  logic signed [ERR_W-1:0]    e_s,
  input  logic signed [SAMPLE_W-1:0] x_s,
  input  logic signed [WEIGHT_W-1:0] w_cur,
  output logic signed [WEIGHT_W-1:0] w_next
);

  localparam int unsigned ProdW = ERR_W + SAMPLE_W;
`ifdef LMS_LEAKAGE_EN
  localparam int unsigned SumW  = WEIGHT_W + 2;
`else
  localparam int unsigned SumW  = WEIGHT_W + 1;
`endif

  logic signed [ProdW-1:0]   prod;
  logic signed [ProdW-1:0]   prod_sh;
  logic signed [SumW-1:0]    sum;
  logic [SumW-WEIGHT_W:0]    sum_top;

  always_comb begin
    prod    = ProdW'(e_s) * ProdW'(x_s);
    prod_sh = prod >>> MU_SHIFT;
`ifdef LMS_LEAKAGE_EN
    sum     = SumW'(w_cur) - SumW'(w_cur >>> LEAK_SHIFT) + SumW'(prod_sh);
`else
    sum     = SumW'(w_cur) + SumW'(prod_sh);
`endif
    // Result fits in 32 bits only when all bits above the weight MSB match it.
    sum_top = sum[SumW-1:WEIGHT_W-1];
    if ((&sum_top) || !(|sum_top)) begin
      w_next = sum[WEIGHT_W-1:0];
    end else if (sum[SumW-1]) begin
      w_next = {1'b1, {(WEIGHT_W-1){1'b0}}};
    end else begin
      w_next = {1'b0, {(WEIGHT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lms_weight_update.sv
// LMS weight updater: snapshots e and the reference buffer, then sweeps one tap per cycle
// through a shared MAC. Define LMS_LEAKAGE_EN to enable weight leakage in the MAC.
module lms_weight_update #(
  parameter int unsigned NTAP     = lms_pkg::NTAP,
  parameter int unsigned MU_SHIFT = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adap_filter_state,
  input  logic                                e_valid,
  input  logic [lms_pkg::ERR_W-1:0]           e,
  input  logic [NTAP*lms_pkg::SAMPLE_W-1:0]   buffer_bus,
  input  logic                                weight_load,
  input  logic [NTAP*lms_pkg::WEIGHT_W-1:0]   weight_init_bus,
  output logic [NTAP*lms_pkg::WEIGHT_W-1:0]   weight_bus,
  output logic                                busy,
  output logic                                done,
  output logic                                e_drop
);
  import lms_pkg::*;

  localparam int unsigned     CntW    = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [CntW-1:0] LastTap = CntW'(NTAP - 1);

  lms_state_e                 state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic signed [ERR_W-1:0]    e_snap_q;
  logic signed [SAMPLE_W-1:0] x_snap_q [NTAP];
  logic signed [WEIGHT_W-1:0] w_q [NTAP];
  logic                       e_drop_q, e_drop_d;
  logic                       start, load_acc, drop, wr_en;
  logic signed [WEIGHT_W-1:0] w_next;

  always_comb begin
    start    = (state_q == StIdle) && e_valid && adap_filter_state && !weight_load;
    load_acc = (state_q == StIdle) && weight_load;
    drop     = e_valid && ((state_q != StIdle) || weight_load);
    wr_en    = (state_q == StUpdate) && adap_filter_state;
    // A drop in the same cycle as an accepted load still leaves the flag set.
    e_drop_d = (e_drop_q && !load_acc) || drop;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StUpdate;
          cnt_d   = '0;
        end
      end
      StUpdate: begin
        if (!adap_filter_state) begin
          state_d = StIdle;
        end else if (cnt_q == LastTap) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  lms_tap_mac #(
    .MU_SHIFT(MU_SHIFT)
  ) u_tap_mac (
    .e_s   (e_snap_q),
    .x_s   (x_snap_q[cnt_q]),
    .w_cur (w_q[cnt_q]),
    .w_next(w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      e_snap_q <= '0;
      e_drop_q <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        x_snap_q[k] <= '0;
        w_q[k]      <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      e_drop_q <= e_drop_d;
      if (start) begin
        e_snap_q <= e;
        for (int k = 0; k < NTAP; k++) begin
          x_snap_q[k] <= buffer_bus[k*SAMPLE_W +: SAMPLE_W];
        end
      end
      if (load_acc) begin
        for (int k = 0; k < NTAP; k++) begin
          w_q[k] <= weight_init_bus[k*WEIGHT_W +: WEIGHT_W];
        end
      end else if (wr_en) begin
        w_q[cnt_q] <= w_next;
      end
    end
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_wbus
    assign weight_bus[k*WEIGHT_W +: WEIGHT_W] = w_q[k];
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign e_drop = e_drop_q;

endmodule
